interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Parametrised interrupt controller for the multicycle processor control path, taking over the single-line `InterruptIn` handling inside the control FSM. It synchronises and edge-detects `N_IRQ` hardware interrupt lines and holds them as pending requests. It masks and priority-encodes them and raises a request to the control FSM only at instruction boundaries. It completes a request/acknowledge handshake that pulses `EPCWrite`, supplies a handler vector for `PCData`, and blocks further requests until the handler executes a return.

## Interface
Parameters:
- `N_IRQ`, 8: number of hardware interrupt lines, 2–16.
- `ID_W`, 3: width of the interrupt ID; must equal ceil(log2(N_IRQ)).
- `VEC_W`, 16: handler vector width; matches PC width.
- `BASE_VEC`, 16'h0F00: vector of IRQ 0.
- `VEC_STRIDE`, 16'h0010: vector spacing between consecutive IDs.
- `MASK_RST`, all ones: reset value of the enable mask.

Ports:
- `CLK`, input, 1: sole clock; all state updates on the rising edge.
- `RESET_N`, input, 1: asynchronous, active-low reset.
- `HardwareInterrupt`, input, N_IRQ: asynchronous interrupt lines; a rising edge requests service.
- `MaskWrite`, input, 1: when high, load `MaskData` into the mask.
- `MaskData`, input, N_IRQ: new mask value; bit = 1 enables that line.
- `InstrBoundary`, input, 1: high while the control FSM is in its fetch state, which is a safe point to take an interrupt.
- `InterruptAck`, input, 1: control FSM accepts the outstanding request.
- `InterruptReturn`, input, 1: return-from-interrupt instruction is executing.
- `InterruptTrue`, output, 1: interrupt request to the control FSM.
- `EPCWrite`, output, 1: one-cycle strobe to save the PC into EPC.
- `IntId`, output, ID_W: ID of the interrupt being requested or serviced.
- `IntVector`, output, VEC_W: handler address.
- `Pending`, output, N_IRQ: pending register, visible for debug and cause reads.
- `Mask`, output, N_IRQ: current mask.
- `Flipped`, output, N_IRQ: bit-reversed `Pending` (`Flipped[i] = Pending[N_IRQ-1-i]`), for the board LED bank.

## Operation
- Input path:
  - Two-flop synchroniser per line, then a previous-value flop.
  - `edge[i] = sync2[i] & ~prev[i]`.
  - `edge[i]` sets `Pending[i]`, independent of the mask.
- Pending bit clear: `Pending[i]` clears only on the cycle `InterruptAck` is accepted for `IntId == i`.
  - If a set and a clear of the same bit coincide, the set wins.
- Mask:
  - `MaskWrite` loads the mask on the next edge.
  - Masking never clears pending bits; unmasking a pending line makes it eligible on the next cycle.
- Eligible set: `Pending & Mask`. The lowest index has the highest priority.
- FSM states:
  - IDLE:
    - If `InstrBoundary` is high and the eligible set is non-zero, latch the winning ID into `IntId` and go to REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - `InterruptTrue` is high.
    - `IntId` and `IntVector` are frozen, even if the mask changes or a higher-priority line arrives.
    - On `InterruptAck`: `EPCWrite` is high for this cycle only, `Pending[IntId]` clears, and the FSM goes to SERVICE.
  - SERVICE:
    - No nesting: the FSM does not re-arm while in this state.
    - Pending bits keep accumulating.
    - On `InterruptReturn`, go to IDLE.
- `InterruptReturn` in IDLE or REQ is ignored.
- `InterruptAck` outside REQ is ignored.
- `IntVector = BASE_VEC + IntId * VEC_STRIDE`, truncated to VEC_W bits (wraps modulo 2^VEC_W).
- `EPCWrite` is combinational: `state == REQ && InterruptAck`.
- `InterruptTrue` is registered state decode: `state == REQ`.
- Reset at any time, including mid-REQ or mid-SERVICE, forces:
  - state IDLE;
  - `Pending`, synchroniser, and previous-value flops to 0;
  - `Mask = MASK_RST`;
  - `IntId = 0`, `IntVector = BASE_VEC`;
  - `InterruptTrue = 0`, `EPCWrite = 0`, `Flipped = 0`.

## Timing
- Let a line rise before clock edge k:
  - `sync1` captures it at edge k.
  - `sync2` captures it at edge k+1.
  - `Pending[i]` = 1 after edge k+2.
- With `InstrBoundary` high and the line unmasked, `InterruptTrue` = 1 after edge k+3. Minimum latency from input to request is 3–4 cycles.
- `InterruptAck` sampled high at edge m:
  - `EPCWrite` is high in the cycle before edge m.
  - After edge m: state is SERVICE, `InterruptTrue` = 0, and the pending bit is cleared.
- `InterruptReturn` at edge r: IDLE after edge r. A new request can rise after edge r+1 at the earliest, given `InstrBoundary`.
- A pulse on `HardwareInterrupt` must be high for at least 2 CLK periods to be captured reliably.
- A line held high is a single request; it must fall and rise again to re-pend.

## Test plan
- Reset with `MASK_RST` = 8'hFF:
  - Drive `HardwareInterrupt` = 8'h08.
  - With `InstrBoundary` = 1: `Pending` = 8'h08 and `Flipped` = 8'h10 after 3 edges; `InterruptTrue` = 1 one edge later; `IntId` = 3; `IntVector` = 16'h0F30.
- Priority: with lines 5 and 2 rising together, the grant is `IntId` = 2.
  - After ack and return, the second grant is `IntId` = 5, `IntVector` = 16'h0F50.
- Masking:
  - With mask 8'hFB, a rise on line 2 gives `Pending` = 8'h04 and no request.
  - Writing mask 8'hFF raises `InterruptTrue` at the next boundary.
- Handshake:
  - Hold REQ for 5 cycles without ack: `IntId` and `IntVector` stay stable, and a line-0 edge does not change `IntId`.
  - Ack: `EPCWrite` is high exactly 1 cycle.
  - A line-0 edge during SERVICE pends but gives no `InterruptTrue` until `InterruptReturn`.
- Boundary gating:
  - With `InstrBoundary` = 0 the request is deferred.
  - Set/clear collision: a new edge on the acked line in the ack cycle leaves `Pending[id]` = 1.
- Reset mid-SERVICE with pending 8'h81:
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - After release, no request is raised until new edges arrive.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Signal bundle between the control FSM and the interrupt controller.
// The master side is the control path (and board I/O driving the IRQ lines),
// the slave side is the interrupt controller itself.
interface interrupt_controller_if #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 3,
  parameter int VEC_W = 16
);
  logic [N_IRQ-1:0] HardwareInterrupt;
  logic             MaskWrite;
  logic [N_IRQ-1:0] MaskData;
  logic             InstrBoundary;
  logic             InterruptAck;
  logic             InterruptReturn;
  logic             InterruptTrue;
  logic             EPCWrite;
  logic [ID_W-1:0]  IntId;
  logic [VEC_W-1:0] IntVector;
  logic [N_IRQ-1:0] Pending;
  logic [N_IRQ-1:0] Mask;
  logic [N_IRQ-1:0] Flipped;

  modport master (
    output HardwareInterrupt, MaskWrite, MaskData, InstrBoundary,
           InterruptAck, InterruptReturn,
    input  InterruptTrue, EPCWrite, IntId, IntVector, Pending, Mask, Flipped
  );

  modport slave (
    input  HardwareInterrupt, MaskWrite, MaskData, InstrBoundary,
           InterruptAck, InterruptReturn,
    output InterruptTrue, EPCWrite, IntId, IntVector, Pending, Mask, Flipped
  );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller for the multicycle control path: synchronises and
// edge-detects the IRQ lines, keeps them pending, masks and priority-encodes
// them (lowest index wins) and hands one request at a time to the control
// FSM at instruction boundaries. No nesting: a new request is only raised
// after the handler has executed its return.
module interrupt_controller #(
  parameter int               N_IRQ      = 8,
  parameter int               ID_W       = 3,
  parameter int               VEC_W      = 16,
  parameter logic [VEC_W-1:0] BASE_VEC   = 16'h0F00,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 16'h0010,
  parameter logic [N_IRQ-1:0] MASK_RST   = '1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  interrupt_controller_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [N_IRQ-1:0] r_sync1;
  logic [N_IRQ-1:0] r_sync2;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [ID_W-1:0]  r_int_id;

  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_elig;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_flipped;
  logic [ID_W-1:0]  w_win_id;
  logic             w_any;
  logic             w_take;
  logic             w_ack_fire;
  logic [VEC_W-1:0] w_vector;

  // Rising edge of each synchronised line, one cycle wide.
  assign w_edge     = r_sync2 & ~r_prev;
  assign w_elig     = r_pending & r_mask;
  assign w_any      = |w_elig;
  assign w_take     = (r_state == S_IDLE) && io_bus.InstrBoundary && w_any;
  assign w_ack_fire = (r_state == S_REQ) && io_bus.InterruptAck;
  // Only the ID being acknowledged is cleared; an edge in the same cycle wins.
  assign w_clr      = w_ack_fire ? (N_IRQ'(1) << r_int_id) : '0;
  assign w_vector   = BASE_VEC + VEC_W'(r_int_id) * VEC_STRIDE;

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= io_bus.HardwareInterrupt;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Pending requests: set by edges regardless of mask, cleared on acceptance.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
    end
  end

  // Enable mask, loaded directly from the bus.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mask <= MASK_RST;
    end else if (io_bus.MaskWrite) begin
      r_mask <= io_bus.MaskData;
    end
  end

  // Lowest eligible index has the highest priority.
  always_comb begin
    w_win_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win_id = ID_W'(i);
      end
    end
  end

  // The granted ID is latched on entry to REQ and frozen until the next grant.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_int_id <= '0;
    end else if (w_take) begin
      r_int_id <= w_win_id;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: ack only matters in REQ, return only in SERVICE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_take) w_state_next = S_REQ;
      S_REQ:     if (io_bus.InterruptAck) w_state_next = S_SERVICE;
      S_SERVICE: if (io_bus.InterruptReturn) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Bit-reversed pending vector for the LED bank.
  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_flip
      assign w_flipped[gi] = r_pending[N_IRQ-1-gi];
    end
  endgenerate

  assign io_bus.InterruptTrue = (r_state == S_REQ);
  assign io_bus.EPCWrite      = w_ack_fire;
  assign io_bus.IntId         = r_int_id;
  assign io_bus.IntVector     = w_vector;
  assign io_bus.Pending       = r_pending;
  assign io_bus.Mask          = r_mask;
  assign io_bus.Flipped       = w_flipped;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: expected grant IDs are queued as lines are
// raised and popped when the controller raises InterruptTrue.
module tb_interrupt_controller;

  localparam int N_IRQ = 8;
  localparam int ID_W  = 3;
  localparam int VEC_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  interrupt_controller_if #(.N_IRQ(N_IRQ), .ID_W(ID_W), .VEC_W(VEC_W)) bus ();

  interrupt_controller #(
    .N_IRQ(N_IRQ), .ID_W(ID_W), .VEC_W(VEC_W),
    .BASE_VEC(16'h0F00), .VEC_STRIDE(16'h0010), .MASK_RST(8'hFF)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .io_bus(bus.slave)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for InterruptTrue; reports whether it arrived.
  task automatic wait_req(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.InterruptTrue === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Drive-only handshake: ack in REQ, then return from SERVICE.
  task automatic ack_and_return();
    bus.InterruptAck = 1'b1;
    tick();
    bus.InterruptAck = 1'b0;
    tick();
    bus.InterruptReturn = 1'b1;
    tick();
    bus.InterruptReturn = 1'b0;
  endtask

  function automatic int pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    n_checks++;
    if (bus.Pending !== 8'h00 || bus.Mask !== 8'hFF || bus.Flipped !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_regs: pending=%h mask=%h flipped=%h, want 00 ff 00", bus.Pending, bus.Mask, bus.Flipped);
    end
    n_checks++;
    if (bus.InterruptTrue !== 1'b0 || bus.EPCWrite !== 1'b0 || bus.IntId !== 3'd0 || bus.IntVector !== 16'h0F00) begin
      n_fail++;
      $display("FAIL reset_outs: itrue=%b epc=%b id=%0d vec=%h, want 0 0 0 0f00", bus.InterruptTrue, bus.EPCWrite, bus.IntId, bus.IntVector);
    end
    rst_n = 1'b1;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_basic();
    int exp;
    bus.HardwareInterrupt = 8'h08;
    exp_q.push_back(3);
    tick(3);
    n_checks++;
    if (bus.Pending !== 8'h08 || bus.Flipped !== 8'h10 || bus.InterruptTrue !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pending: pending=%h flipped=%h itrue=%b, want 08 10 0", bus.Pending, bus.Flipped, bus.InterruptTrue);
    end
    tick();
    exp = pop_exp();
    n_checks++;
    if (bus.InterruptTrue !== 1'b1 || bus.IntId !== ID_W'(exp) || bus.IntVector !== 16'h0F30) begin
      n_fail++;
      $display("FAIL basic_req: itrue=%b id=%0d vec=%h, want 1 %0d 0f30", bus.InterruptTrue, bus.IntId, bus.IntVector, exp);
    end
    bus.InterruptAck = 1'b1;
    #1;
    n_checks++;
    if (bus.EPCWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_epc: epcwrite=%b, want 1", bus.EPCWrite);
    end
    tick();
    bus.InterruptAck = 1'b0;
    #1;
    n_checks++;
    if (bus.InterruptTrue !== 1'b0 || bus.Pending !== 8'h00 || bus.EPCWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_ack: itrue=%b pending=%h epc=%b, want 0 00 0", bus.InterruptTrue, bus.Pending, bus.EPCWrite);
    end
    bus.InterruptReturn = 1'b1;
    tick();
    bus.InterruptReturn = 1'b0;
    bus.HardwareInterrupt = 8'h00;
    tick(4);
    $display("txn basic id=%0d vec=%h", bus.IntId, bus.IntVector);
  endtask

  task automatic test_priority();
    bit ok;
    int exp;
    bus.HardwareInterrupt = 8'h24;
    exp_q.push_back(2);
    exp_q.push_back(5);
    for (int g = 0; g < 2; g++) begin
      wait_req(12, ok);
      exp = pop_exp();
      n_checks++;
      if (!ok || bus.IntId !== ID_W'(exp) || bus.IntVector !== (16'h0F00 + 16'(exp) * 16'h0010)) begin
        n_fail++;
        $display("FAIL priority_grant%0d: ok=%b id=%0d vec=%h, want id %0d", g, ok, bus.IntId, bus.IntVector, exp);
      end
      $display("txn priority grant id=%0d vec=%h", bus.IntId, bus.IntVector);
      ack_and_return();
    end
    bus.HardwareInterrupt = 8'h00;
    tick(4);
  endtask

  task automatic test_masking();
    int exp;
    bus.MaskWrite = 1'b1;
    bus.MaskData  = 8'hFB;
    tick();
    bus.MaskWrite = 1'b0;
    bus.HardwareInterrupt = 8'h04;
    tick(6);
    n_checks++;
    if (bus.Mask !== 8'hFB || bus.Pending !== 8'h04 || bus.InterruptTrue !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_hold: mask=%h pending=%h itrue=%b, want fb 04 0", bus.Mask, bus.Pending, bus.InterruptTrue);
    end
    exp_q.push_back(2);
    bus.MaskWrite = 1'b1;
    bus.MaskData  = 8'hFF;
    tick();
    bus.MaskWrite = 1'b0;
    tick();
    exp = pop_exp();
    n_checks++;
    if (bus.InterruptTrue !== 1'b1 || bus.IntId !== ID_W'(exp)) begin
      n_fail++;
      $display("FAIL mask_release: itrue=%b id=%0d, want 1 %0d", bus.InterruptTrue, bus.IntId, exp);
    end
    $display("txn masking grant id=%0d", bus.IntId);
    ack_and_return();
    bus.HardwareInterrupt = 8'h00;
    tick(4);
  endtask

  task automatic test_handshake();
    bit ok;
    int exp;
    bus.HardwareInterrupt = 8'h10;
    exp_q.push_back(4);
    wait_req(12, ok);
    exp = pop_exp();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) bus.HardwareInterrupt = 8'h11;
      n_checks++;
      if (!ok || bus.InterruptTrue !== 1'b1 || bus.IntId !== ID_W'(exp) || bus.IntVector !== 16'h0F40) begin
        n_fail++;
        $display("FAIL hold_req_c%0d: itrue=%b id=%0d vec=%h, want 1 %0d 0f40", c, bus.InterruptTrue, bus.IntId, bus.IntVector, exp);
      end
      tick();
    end
    n_checks++;
    if (bus.Pending !== 8'h11 || bus.IntId !== ID_W'(exp)) begin
      n_fail++;
      $display("FAIL hold_pending: pending=%h id=%0d, want 11 %0d", bus.Pending, bus.IntId, exp);
    end
    bus.InterruptAck = 1'b1;
    #1;
    n_checks++;
    if (bus.EPCWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL epc_on: epcwrite=%b, want 1", bus.EPCWrite);
    end
    tick();
    #1;
    n_checks++;
    if (bus.EPCWrite !== 1'b0 || bus.InterruptTrue !== 1'b0 || bus.Pending !== 8'h01) begin
      n_fail++;
      $display("FAIL epc_once: epc=%b itrue=%b pending=%h, want 0 0 01", bus.EPCWrite, bus.InterruptTrue, bus.Pending);
    end
    bus.InterruptAck = 1'b0;
    bus.HardwareInterrupt = 8'h51;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (bus.InterruptTrue !== 1'b0) begin
        n_fail++;
        $display("FAIL service_no_nest_c%0d: itrue=%b, want 0", c, bus.InterruptTrue);
      end
    end
    n_checks++;
    if (bus.Pending !== 8'h41 && bus.Pending !== 8'h51) begin
      n_fail++;
      $display("FAIL service_pend: pending=%h, want 41", bus.Pending);
    end
    exp_q.push_back(0);
    exp_q.push_back(6);
    bus.InterruptReturn = 1'b1;
    tick();
    bus.InterruptReturn = 1'b0;
    tick();
    exp = pop_exp();
    n_checks++;
    if (bus.InterruptTrue !== 1'b1 || bus.IntId !== ID_W'(exp)) begin
      n_fail++;
      $display("FAIL after_return: itrue=%b id=%0d, want 1 %0d", bus.InterruptTrue, bus.IntId, exp);
    end
    $display("txn handshake grant id=%0d", bus.IntId);
    ack_and_return();
    wait_req(12, ok);
    exp = pop_exp();
    n_checks++;
    if (!ok || bus.IntId !== ID_W'(exp) || bus.IntVector !== 16'h0F60) begin
      n_fail++;
      $display("FAIL handshake_second: ok=%b id=%0d vec=%h, want %0d 0f60", ok, bus.IntId, bus.IntVector, exp);
    end
    $display("txn handshake grant id=%0d", bus.IntId);
    ack_and_return();
    bus.HardwareInterrupt = 8'h00;
    tick(4);
  endtask

  task automatic test_boundary();
    bit ok;
    int exp;
    bus.InstrBoundary = 1'b0;
    bus.HardwareInterrupt = 8'h02;
    tick(6);
    n_checks++;
    if (bus.Pending !== 8'h02 || bus.InterruptTrue !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_defer: pending=%h itrue=%b, want 02 0", bus.Pending, bus.InterruptTrue);
    end
    exp_q.push_back(1);
    bus.InstrBoundary = 1'b1;
    tick();
    exp = pop_exp();
    n_checks++;
    if (bus.InterruptTrue !== 1'b1 || bus.IntId !== ID_W'(exp)) begin
      n_fail++;
      $display("FAIL boundary_take: itrue=%b id=%0d, want 1 %0d", bus.InterruptTrue, bus.IntId, exp);
    end
    $display("txn boundary grant id=%0d", bus.IntId);
    // Re-edge line 1 so its set lands on the same edge that accepts the ack.
    bus.HardwareInterrupt = 8'h00;
    tick(4);
    bus.HardwareInterrupt = 8'h02;
    tick(2);
    bus.InterruptAck = 1'b1;
    tick();
    bus.InterruptAck = 1'b0;
    n_checks++;
    if (bus.Pending !== 8'h02 || bus.InterruptTrue !== 1'b0) begin
      n_fail++;
      $display("FAIL collision: pending=%h itrue=%b, want 02 0", bus.Pending, bus.InterruptTrue);
    end
    exp_q.push_back(1);
    bus.InterruptReturn = 1'b1;
    tick();
    bus.InterruptReturn = 1'b0;
    wait_req(12, ok);
    exp = pop_exp();
    n_checks++;
    if (!ok || bus.IntId !== ID_W'(exp)) begin
      n_fail++;
      $display("FAIL collision_regrant: ok=%b id=%0d, want %0d", ok, bus.IntId, exp);
    end
    $display("txn collision regrant id=%0d", bus.IntId);
    ack_and_return();
    bus.HardwareInterrupt = 8'h00;
    tick(4);
  endtask

  task automatic test_reset_mid_service();
    bit ok;
    int exp;
    bus.HardwareInterrupt = 8'h02;
    exp_q.push_back(1);
    wait_req(12, ok);
    exp = pop_exp();
    n_checks++;
    if (!ok || bus.IntId !== ID_W'(exp)) begin
      n_fail++;
      $display("FAIL midrst_grant: ok=%b id=%0d, want %0d", ok, bus.IntId, exp);
    end
    bus.InterruptAck = 1'b1;
    tick();
    bus.InterruptAck = 1'b0;
    bus.HardwareInterrupt = 8'h83;
    tick(3);
    n_checks++;
    if (bus.Pending !== 8'h81 || bus.InterruptTrue !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pending: pending=%h itrue=%b, want 81 0", bus.Pending, bus.InterruptTrue);
    end
    #2;
    rst_n = 1'b0;
    bus.InterruptAck = 1'b1;
    #1;
    n_checks++;
    if (bus.Pending !== 8'h00 || bus.Flipped !== 8'h00 || bus.Mask !== 8'hFF || bus.IntId !== 3'd0 ||
        bus.IntVector !== 16'h0F00 || bus.InterruptTrue !== 1'b0 || bus.EPCWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pending=%h flipped=%h mask=%h id=%0d vec=%h itrue=%b epc=%b",
               bus.Pending, bus.Flipped, bus.Mask, bus.IntId, bus.IntVector, bus.InterruptTrue, bus.EPCWrite);
    end
    bus.InterruptAck = 1'b0;
    bus.HardwareInterrupt = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(8);
    n_checks++;
    if (bus.InterruptTrue !== 1'b0 || bus.Pending !== 8'h00) begin
      n_fail++;
      $display("FAIL post_reset_quiet: itrue=%b pending=%h, want 0 00", bus.InterruptTrue, bus.Pending);
    end
    bus.HardwareInterrupt = 8'h40;
    exp_q.push_back(6);
    wait_req(12, ok);
    exp = pop_exp();
    n_checks++;
    if (!ok || bus.IntId !== ID_W'(exp) || bus.IntVector !== 16'h0F60) begin
      n_fail++;
      $display("FAIL post_reset_grant: ok=%b id=%0d vec=%h, want %0d 0f60", ok, bus.IntId, bus.IntVector, exp);
    end
    $display("txn reset-mid-service regrant id=%0d", bus.IntId);
    ack_and_return();
    bus.HardwareInterrupt = 8'h00;
    tick(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
  endtask

  initial begin
    bus.HardwareInterrupt = '0;
    bus.MaskWrite         = 1'b0;
    bus.MaskData          = '0;
    bus.InstrBoundary     = 1'b1;
    bus.InterruptAck      = 1'b0;
    bus.InterruptReturn   = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_masking();
    test_handshake();
    test_boundary();
    test_reset_mid_service();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
